// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch sequencer with 2-entry instruction queue and jump redirect
// Optional feature: IFETCH_DIR_EN adds the dir port for down-counting fetch.
module ifetch #(
    parameter int                 ADDR_W   = 10,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef IFETCH_DIR_EN
    input  logic              dir,
`endif
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmpLoc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              infl_q, infl_d;
    logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
    logic [DATA_W-1:0] data_q [2];
    logic [ADDR_W-1:0] tag_q  [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic              wr_idx;
    logic [2:0]        occ_after_pop;
    logic [ADDR_W-1:0] pc_step;

    assign instr_valid = (count_q != 2'd0);
    assign pop         = instr_valid & instr_ready;
    assign push        = infl_q & ~jmp;

    // Queue slots plus the read in flight, minus the one leaving this cycle, bound the issue.
    assign occ_after_pop = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
    assign issue         = rst & en & ~jmp & (occ_after_pop < 3'd2);

    // With count=2 and a pop the tail lands on the slot the head is vacating.
    assign wr_idx = rd_ptr_q ^ count_q[0];

`ifdef IFETCH_DIR_EN
    assign pc_step = dir ? (pc_q + 1'b1) : (pc_q - 1'b1);
`else
    assign pc_step = pc_q + 1'b1;
`endif

    always_comb begin
        pc_d        = pc_q;
        infl_d      = 1'b0;
        infl_addr_d = infl_addr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (jmp) begin
            pc_d     = jmpLoc;
            infl_d   = 1'b0;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d        = pc_step;
                infl_addr_d = pc_q;
            end
            infl_d   = issue;
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            infl_q      <= infl_d;
            infl_addr_q <= infl_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            if (push) begin
                data_q[wr_idx] <= imem_data;
                tag_q[wr_idx]  <= infl_addr_q;
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign imem_rd   = issue;
    assign instr     = data_q[rd_ptr_q];
    assign instr_pc  = tag_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - randomized self-checking bench for ifetch against a queue-based reference model
module tb_ifetch;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          dir = 1'b1;
    logic          jmp = 1'b0;
    logic [AW-1:0] jmpLoc = '0;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] imem_data = '0;
    logic [AW-1:0] imem_addr, instr_pc, pc;
    logic          imem_rd, instr_valid;
    logic [DW-1:0] instr;

    ifetch dut (
        .clk(clk), .rst(rst), .en(en),
`ifdef IFETCH_DIR_EN
        .dir(dir),
`endif
        .jmp(jmp), .jmpLoc(jmpLoc),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return {a, 22'h0} ^ (32'(a) * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    // Memory answers one cycle after a read; garbage otherwise so stray captures show up.
    always @(posedge clk) imem_data <= imem_rd ? word_at(imem_addr) : $urandom();

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } item_t;
    item_t         q[$];
    logic [AW-1:0] m_pc;
    int            cyc;

    logic          exp_rd, exp_valid, exp_pop;
    logic [53:0]   obs_v, exp_v;

    task automatic model_reset();
        q.delete();
        m_pc = '0;
        cyc  = 0;
    endtask

    task automatic apply(input logic e, input logic j, input logic [AW-1:0] jl,
                         input logic r, input logic d);
        logic [AW-1:0] e_ipc;
        logic [DW-1:0] e_ins;
        en = e; jmp = j; jmpLoc = jl; instr_ready = r; dir = d;
        #1;
        exp_valid = (q.size() > 0) && (cyc - q[0].cyc >= 2);
        e_ipc     = exp_valid ? q[0].addr : '0;
        e_ins     = exp_valid ? word_at(q[0].addr) : '0;
        exp_pop   = exp_valid && r;
        exp_rd    = e && !j && ((q.size() - (exp_pop ? 1 : 0)) < 2);
        exp_v     = {exp_rd, m_pc, exp_valid, e_ipc, e_ins};
        obs_v     = {imem_rd, imem_addr, instr_valid,
                     exp_valid ? instr_pc : 10'd0, exp_valid ? instr : 32'd0};
    endtask

    task automatic advance();
        if (exp_pop) void'(q.pop_front());
        if (jmp) begin
            q.delete();
            m_pc = jmpLoc;
        end else if (exp_rd) begin
            q.push_back('{addr: m_pc, cyc: cyc});
`ifdef IFETCH_DIR_EN
            m_pc = dir ? m_pc + 1'b1 : m_pc - 1'b1;
`else
            m_pc = m_pc + 1'b1;
`endif
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        en = 1'b1; instr_ready = 1'b1; jmp = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({pc, imem_addr, imem_rd, instr_valid} !== {10'd0, 10'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl got pc=%0d addr=%0d rd=%b v=%b want 0 0 0 0", pc, imem_addr, imem_rd, instr_valid);
        end
        n_chk++;
        if ({instr, instr_pc} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_data got instr=%h instr_pc=%0d want 0 0", instr, instr_pc);
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        int first_v = -1;
        for (int i = 0; i < 12; i++) begin
            apply(1, 0, '0, 1, 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL stream cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (instr_valid && first_v < 0) first_v = i;
            advance();
        end
        n_chk++;
        if (first_v !== 2) begin n_fail++; $display("FAIL first_valid got cycle %0d want 2", first_v); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 14; i++) begin
            apply(1, 0, '0, (i >= 6), 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL backpressure cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            advance();
        end
    endtask

    task automatic test_jump();
        int lat = -1;
        for (int g = 0; g < 40 && m_pc < 20; g++) begin
            apply(1, 0, '0, 1, 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL jump_pre cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            advance();
        end
        apply(1, 1, 10'd69, 1, 1);
        n_chk++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL jump_cyc cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
        advance();
        for (int k = 1; k <= 6; k++) begin
            apply(1, 0, '0, 1, 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL jump_post cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (instr_valid && instr_pc == 10'd69 && lat < 0) lat = k;
            advance();
        end
        n_chk++;
        if (lat !== 3) begin n_fail++; $display("FAIL jump_latency got %0d want 3", lat); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] got[$];
        logic [39:0]   seq;
        apply(1, 1, 10'd1022, 1, 1);
        n_chk++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL wrap_jmp cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
        advance();
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, '0, 1, 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (instr_valid && instr_ready) got.push_back(instr_pc);
            advance();
        end
        seq = (got.size() >= 4) ? {got[0], got[1], got[2], got[3]} : '1;
        n_chk++;
        if (seq !== {10'd1022, 10'd1023, 10'd0, 10'd1}) begin
            n_fail++; $display("FAIL wrap_seq got %h want %h", seq, {10'd1022, 10'd1023, 10'd0, 10'd1});
        end
    endtask

    task automatic test_enable();
        int rd_seen = 0;
        for (int i = 0; i < 13; i++) begin
            apply(!(i >= 3 && i < 7), 0, '0, 1, 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL enable cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (i >= 3 && i < 7 && imem_rd) rd_seen++;
            advance();
        end
        n_chk++;
        if (rd_seen !== 0) begin n_fail++; $display("FAIL enable_idle got %0d reads want 0", rd_seen); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] got[$];
        logic [AW-1:0] first;
        apply(1, 1, 10'd300, 1, 1); advance();
        apply(1, 1, 10'd500, 1, 1);
        n_chk++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL b2b_jmp cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
        advance();
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, '0, 1, 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL b2b cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (instr_valid && instr_ready) got.push_back(instr_pc);
            advance();
        end
        first = (got.size() > 0) ? got[0] : '1;
        n_chk++;
        if (first !== 10'd500) begin n_fail++; $display("FAIL b2b_target got %0d want 500", first); end
    endtask

`ifdef IFETCH_DIR_EN
    task automatic test_dir();
        logic [AW-1:0] got[$];
        logic [69:0]   seq;
        apply(1, 1, 10'd5, 1, 0); advance();
        for (int i = 0; i < 10; i++) begin
            apply(1, 0, '0, 1, 0);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL dir_down cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (instr_valid && instr_ready) got.push_back(instr_pc);
            advance();
        end
        seq = (got.size() >= 7) ? {got[0], got[1], got[2], got[3], got[4], got[5], got[6]} : '1;
        n_chk++;
        if (seq !== {10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd0, 10'd1023}) begin
            n_fail++; $display("FAIL dir_seq got %h", seq);
        end
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, '0, 1, 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL dir_up cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            advance();
        end
    endtask
`endif

    task automatic test_random();
        logic d;
        for (int i = 0; i < 400; i++) begin
`ifdef IFETCH_DIR_EN
            d = 1'($urandom_range(0, 1));
`else
            d = 1'b1;
`endif
            apply($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
                  AW'($urandom()), $urandom_range(0, 9) < 6, d);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        apply(1, 1, 10'd40, 1, 1); advance();
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, '0, (i < 2), 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL rstmid_pre cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            if (i < 5) advance();
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({instr_valid, imem_rd, pc, imem_addr} !== {1'b0, 1'b0, 10'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL rstmid got v=%b rd=%b pc=%0d addr=%0d want 0 0 0 0", instr_valid, imem_rd, pc, imem_addr);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1, 0, '0, 1, 1);
            n_chk++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL rstmid_post cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_wrap();
        test_enable();
        test_back_to_back();
`ifdef IFETCH_DIR_EN
        test_dir();
`endif
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch sequencer for the Harvard MIPS core. It sits between the 10-bit program counter and the instruction memory read port on one side, and the decoder on the other. It owns the fetch address and issues instruction-memory reads, which return data one cycle later. Returned instructions are buffered in a 2-entry queue and handed to the decoder over a valid/ready handshake, with a jump redirect that flushes in-flight work.

## Interface
- ADDR_W, 10, fetch address width (matches program counter width)
- DATA_W, 32, instruction width
- RESET_PC, 0, fetch address loaded on reset

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  fetch enable; 0 stalls issue, buffered instructions still drain
- dir  in  1  count direction, 1 = up, 0 = down (only with IFETCH_DIR_EN)
- jmp  in  1  redirect request, sampled on clk
- jmpLoc  in  ADDR_W  redirect target
- imem_addr  out  ADDR_W  instruction memory read address, equals pc register
- imem_rd  out  1  read strobe; data is returned on imem_data the next cycle
- imem_data  in  DATA_W  read data, valid the cycle after imem_rd
- instr  out  DATA_W  head-of-queue instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decoder accepts instr when instr_valid & instr_ready
- pc  out  ADDR_W  current fetch address

## Operation
- State:
  - pc register;
  - inflight flag plus an inflight address, for the read issued last cycle;
  - 2-entry FIFO of {instr, instr_pc}, with count 0..2.
- pop = instr_valid & instr_ready.
- Read issue, imem_rd = en & ~jmp & (count + inflight - pop < 2):
  - combinational from registered state and inputs;
  - sustains 1 instruction/cycle while instr_ready is held high.
- On an issue edge, pc advances by +1. With IFETCH_DIR_EN and dir=0, it advances by -1 instead.
- pc arithmetic is modulo 2^ADDR_W:
  - counting up, 2^ADDR_W-1 wraps to 0;
  - counting down, 0 wraps to 2^ADDR_W-1.
- Response capture: if inflight is set, imem_data and the inflight address are pushed at the next edge.
- Push and pop in the same cycle is legal at any count, including count=2 with pop.
- Jump, at an edge with jmp=1:
  - pc is loaded with jmpLoc;
  - FIFO count is cleared;
  - inflight is cleared and the returning data is discarded;
  - no read is issued in the jmp cycle.
- A handshake completing in the jmp cycle is a valid, older instruction and is consumed normally.
- jmp has priority over en, issue and push.
- en=0: no issue; inflight data is still captured and the queue still drains.
- FIFO order is strict issue order; no entry is ever overwritten or dropped except by jmp.

## Timing
- Reset values:
  - pc=RESET_PC, imem_addr=RESET_PC, imem_rd=0 while rst low;
  - instr_valid=0, count=0, inflight=0;
  - instr and instr_pc = 0.
- Reset asserted mid-operation clears everything asynchronously; pending data is lost.
- First read after reset release: imem_rd rises in the first cycle with en=1, at address RESET_PC.
- Latency: read issued in cycle N → data on imem_data in N+1 → pushed at the end of N+1 → instr_valid high in N+2.
- Jump latency:
  - jmp high in cycle J → instr_valid=0 and imem_addr=jmpLoc in J+1;
  - the read of jmpLoc is issued in J+1;
  - instr_pc=jmpLoc is valid in J+3.
- Back-to-back jmp: each jmp reloads pc; only the last target is fetched.
- instr and instr_pc are stable while instr_valid=1 and instr_ready=0.

## Configuration
- IFETCH_DIR_EN defined:
  - dir port present;
  - dir=0 decrements pc per issue, with wrap per Operation;
  - dir may change any cycle and affects the next issue only.
- Undefined: no dir port, pc only increments.

## Test plan
- Reset, hold instr_ready=1, en=1, imem returns data equal to address:
  - imem_addr steps 0,1,2…;
  - first instr_valid 2 cycles after the first imem_rd;
  - instr_pc=0,1,2… with no gaps.
- Backpressure:
  - instr_ready=0 for 6 cycles → imem_rd stops after 2 outstanding; instr held at 0.
  - Release ready → instr_pc 0,1,2,3 in order, no loss or duplication.
- Jump: while streaming at pc≈20, pulse jmp with jmpLoc=69 →
  - next cycle instr_valid=0 and imem_addr=69;
  - the in-flight word is discarded;
  - instr_pc=69 appears 3 cycles after the jmp cycle, then 70, 71.
- Wrap: jmp to 1022 → instr_pc 1022, 1023, 0, 1.
- en=0 for 4 cycles mid-stream → no imem_rd during that window; queued and in-flight instructions still delivered; resumes at the correct pc.
- IFETCH_DIR_EN: run at 5 with dir=0 → instr_pc 5,4,3,2,1,0,1023; flipping dir=1 mid-stream → next issued address increments.
- Reset asserted mid-stream with count=2 → instr_valid, imem_rd and count go to 0 immediately; pc=RESET_PC.
